sprite_motion_scorer: RTL and testbench

// - Parametrised per-frame sprite motion and scoring unit for the VGA game path; sits between the VGATimingGenerator/switch inputs and the sprite ROM and compositor.
// - Moves one sprite by a programmable step once per frame, clamps it to the screen, and tracks left/right goal crossings with hysteresis.
// - Drives two saturating score counters and a registered pixel hit test with the sprite ROM address for the compositor.

---
 rtl/sprite_motion_scorer_if.sv | 36 +++
 rtl/sprite_motion_scorer.sv | 170 +++++++++++++++++
 tb/tb_sprite_motion_scorer.sv | 220 ++++++++++++++++++++++
 3 files changed

// File: rtl/sprite_motion_scorer_if.sv
// Signal bundle between the game input/timing side (master) and sprite_motion_scorer (slave).
interface sprite_motion_scorer_if #(
    parameter int X_W     = 10,
    parameter int Y_W     = 9,
    parameter int STEP_W  = 4,
    parameter int SCORE_W = 8,
    parameter int ROM_AW  = 18
);
    logic               frame_end;
    logic               mv_left;
    logic               mv_right;
    logic               mv_up;
    logic               mv_down;
    logic [STEP_W-1:0]  step;
    logic               score_clear;
    logic [X_W-1:0]     pix_x;
    logic [Y_W-1:0]     pix_y;
    logic [X_W-1:0]     pos_x;
    logic [Y_W-1:0]     pos_y;
    logic [SCORE_W-1:0] score_l;
    logic [SCORE_W-1:0] score_r;
    logic               goal_l;
    logic               goal_r;
    logic               hit;
    logic [ROM_AW-1:0]  rom_addr;

    modport master (
        output frame_end, mv_left, mv_right, mv_up, mv_down, step, score_clear, pix_x, pix_y,
        input  pos_x, pos_y, score_l, score_r, goal_l, goal_r, hit, rom_addr
    );

    modport slave (
        input  frame_end, mv_left, mv_right, mv_up, mv_down, step, score_clear, pix_x, pix_y,
        output pos_x, pos_y, score_l, score_r, goal_l, goal_r, hit, rom_addr
    );
endinterface

// File: rtl/sprite_motion_scorer.sv
// Per-frame sprite motion, goal detection with hysteresis, saturating scores and pixel hit test.
// Define SCORE_BCD_EN for packed-BCD scores saturating at all-9s; otherwise binary saturating at SCORE_MAX.
module sprite_motion_scorer #(
    parameter int SCREEN_W     = 640,
    parameter int SCREEN_H     = 480,
    parameter int X_W          = 10,
    parameter int Y_W          = 9,
    parameter int SPRITE_DIM   = 50,
    parameter int START_X      = 295,
    parameter int START_Y      = 215,
    parameter int LEFT_GOAL_X  = 160,
    parameter int RIGHT_GOAL_X = 430,
    parameter int STEP_W       = 4,
    parameter int SCORE_W      = 8,
    parameter int SCORE_MAX    = 99,
    parameter int GLYPH_BASE   = 15,
    parameter int ROM_AW       = 18
) (
    input logic                   clk,
    input logic                   reset,
    sprite_motion_scorer_if.slave bus
);
    localparam logic [X_W:0]        X_MAX     = (X_W+1)'(SCREEN_W - SPRITE_DIM);
    localparam logic [Y_W:0]        Y_MAX     = (Y_W+1)'(SCREEN_H - SPRITE_DIM);
    localparam logic [X_W:0]        DIM_X     = (X_W+1)'(SPRITE_DIM);
    localparam logic [Y_W:0]        DIM_Y     = (Y_W+1)'(SPRITE_DIM);
    localparam logic [X_W-1:0]      GOAL_L    = X_W'(LEFT_GOAL_X);
    localparam logic [X_W-1:0]      GOAL_R    = X_W'(RIGHT_GOAL_X);
    localparam logic [ROM_AW-1:0]   GLYPH_OFS = ROM_AW'(GLYPH_BASE * SPRITE_DIM * SPRITE_DIM);
    localparam logic [ROM_AW-1:0]   DIM_ROM   = ROM_AW'(SPRITE_DIM);

    typedef enum logic {ARMED, LATCHED} goalState_t;

    goalState_t     state, stateNext;
    logic           frameEndQ, tick, tickQ;
    logic           incL, incR;
    logic [X_W:0]   xDec, xInc;
    logic [Y_W:0]   yDec, yInc;
    logic [X_W-1:0] xNext, dx;
    logic [Y_W-1:0] yNext, dy;
    logic           hitNow;

`ifdef SCORE_BCD_EN
    localparam logic [SCORE_W-1:0] ALL_NINES = {(SCORE_W/4){4'h9}};

    function automatic logic [SCORE_W-1:0] scoreInc(input logic [SCORE_W-1:0] s);
        logic [SCORE_W-1:0] r;
        logic carry;
        r = s;
        carry = 1'b1;
        if (s != ALL_NINES) begin
            for (int d = 0; d < SCORE_W/4; d++) begin
                if (carry) begin
                    if (s[4*d +: 4] == 4'd9) begin
                        r[4*d +: 4] = 4'd0;
                    end else begin
                        r[4*d +: 4] = s[4*d +: 4] + 4'd1;
                        carry = 1'b0;
                    end
                end
            end
        end
        return r;
    endfunction
`else
    function automatic logic [SCORE_W-1:0] scoreInc(input logic [SCORE_W-1:0] s);
        return (s >= SCORE_W'(SCORE_MAX)) ? s : s + SCORE_W'(1);
    endfunction
`endif

    assign tick = bus.frame_end & ~frameEndQ;

    // The extra top bit of xDec/yDec flags an underflow below zero.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path leaves it unassigned (latch).
        xDec  = {1'b0, bus.pos_x} - (X_W+1)'(bus.step);
        xInc  = {1'b0, bus.pos_x} + (X_W+1)'(bus.step);
        yDec  = {1'b0, bus.pos_y} - (Y_W+1)'(bus.step);
        yInc  = {1'b0, bus.pos_y} + (Y_W+1)'(bus.step);
        xNext = bus.pos_x;
        yNext = bus.pos_y;
        if (tick) begin
            if (bus.mv_left)       xNext = xDec[X_W] ? '0 : xDec[X_W-1:0];
            else if (bus.mv_right) xNext = (xInc > X_MAX) ? X_MAX[X_W-1:0] : xInc[X_W-1:0];
            else if (bus.mv_up)    yNext = yDec[Y_W] ? '0 : yDec[Y_W-1:0];
            else if (bus.mv_down)  yNext = (yInc > Y_MAX) ? Y_MAX[Y_W-1:0] : yInc[Y_W-1:0];
        end
    end

    always_comb begin
        stateNext = state;
        incL      = 1'b0;
        incR      = 1'b0;
        if (tickQ) begin
            case (state)
                ARMED: begin
                    if (bus.pos_x < GOAL_L) begin
                        incR      = 1'b1;
                        stateNext = LATCHED;
                    end else if (bus.pos_x > GOAL_R) begin
                        incL      = 1'b1;
                        stateNext = LATCHED;
                    end
                end
                LATCHED: begin
                    if (bus.pos_x > GOAL_L && bus.pos_x < GOAL_R) stateNext = ARMED;
                end
                default: stateNext = ARMED;
            endcase
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            frameEndQ <= 1'b1;
            tickQ     <= 1'b0;
            state     <= ARMED;
            bus.pos_x <= X_W'(START_X);
            bus.pos_y <= Y_W'(START_Y);
        end else begin
            frameEndQ <= bus.frame_end;
            tickQ     <= tick;
            state     <= stateNext;
            bus.pos_x <= xNext;
            bus.pos_y <= yNext;
        end
    end

    // A clear beats a same-cycle goal, including its pulse.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            bus.score_l <= '0;
            bus.score_r <= '0;
            bus.goal_l  <= 1'b0;
            bus.goal_r  <= 1'b0;
        end else begin
            bus.goal_l <= 1'b0;
            bus.goal_r <= 1'b0;
            if (bus.score_clear) begin
                bus.score_l <= '0;
                bus.score_r <= '0;
            end else begin
                if (incL) begin
                    bus.goal_l  <= 1'b1;
                    bus.score_l <= scoreInc(bus.score_l);
                end
                if (incR) begin
                    bus.goal_r  <= 1'b1;
                    bus.score_r <= scoreInc(bus.score_r);
                end
            end
        end
    end

    assign dx     = bus.pix_x - bus.pos_x;
    assign dy     = bus.pix_y - bus.pos_y;
    assign hitNow = (bus.pix_x > bus.pos_x) && ({1'b0, bus.pix_x} < {1'b0, bus.pos_x} + DIM_X) &&
                    (bus.pix_y > bus.pos_y) && ({1'b0, bus.pix_y} < {1'b0, bus.pos_y} + DIM_Y);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            bus.hit      <= 1'b0;
            bus.rom_addr <= '0;
        end else begin
            bus.hit      <= hitNow;
            bus.rom_addr <= GLYPH_OFS + ROM_AW'(dx) + DIM_ROM * ROM_AW'(dy);
        end
    end
endmodule

// File: tb/tb_sprite_motion_scorer.sv
// Directed self-checking bench for sprite_motion_scorer: motion, clamping, goals, scores, hit test, reset.
module tb_sprite_motion_scorer;
`ifdef SCORE_BCD_EN
    localparam logic [7:0] SAT   = 8'h99;
    localparam logic [7:0] TEN   = 8'h10;
`else
    localparam logic [7:0] SAT   = 8'd99;
    localparam logic [7:0] TEN   = 8'd10;
`endif

    logic clk = 1'b0;
    logic reset;
    int   nChecks = 0;
    int   nFail = 0;
    int   goalLCnt = 0;
    int   goalRCnt = 0;
    int   cntBefore;

    sprite_motion_scorer_if sif ();
    sprite_motion_scorer dut (.clk(clk), .reset(reset), .bus(sif.slave));

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (sif.goal_l === 1'b1) goalLCnt++;
        if (sif.goal_r === 1'b1) goalRCnt++;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nChecks++;
        assert (obs === exp) else begin
            nFail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic doFrame(input bit l, input bit r, input bit u, input bit d,
                           input logic [3:0] s, input bit clr);
        sif.mv_left  = l;
        sif.mv_right = r;
        sif.mv_up    = u;
        sif.mv_down  = d;
        sif.step     = s;
        sif.frame_end = 1'b1;
        @(negedge clk);
        if (clr) sif.score_clear = 1'b1;
        @(negedge clk);
        sif.score_clear = 1'b0;
        sif.frame_end = 1'b0;
        @(negedge clk);
        @(negedge clk);
    endtask

    task automatic left(input logic [3:0] s);
        doFrame(1'b1, 1'b0, 1'b0, 1'b0, s, 1'b0);
    endtask

    task automatic right(input logic [3:0] s);
        doFrame(1'b0, 1'b1, 1'b0, 1'b0, s, 1'b0);
    endtask

    task automatic up(input logic [3:0] s);
        doFrame(1'b0, 1'b0, 1'b1, 1'b0, s, 1'b0);
    endtask

    initial begin
        reset = 1'b1;
        sif.frame_end = 1'b0;
        sif.mv_left = 1'b0;
        sif.mv_right = 1'b0;
        sif.mv_up = 1'b0;
        sif.mv_down = 1'b0;
        sif.step = '0;
        sif.score_clear = 1'b0;
        sif.pix_x = '0;
        sif.pix_y = '0;
        repeat (2) @(negedge clk);
        check("rst_pos_x", sif.pos_x, 295);
        check("rst_pos_y", sif.pos_y, 215);
        check("rst_score_l", sif.score_l, 0);
        check("rst_score_r", sif.score_r, 0);
        check("rst_goals", {sif.goal_l, sif.goal_r}, 0);
        check("rst_hit", sif.hit, 0);
        check("rst_rom_addr", sif.rom_addr, 0);
        reset = 1'b0;
        repeat (2) @(negedge clk);

        // Long frame_end pulse gives exactly one move.
        sif.mv_right = 1'b1;
        sif.step = 4'd3;
        sif.frame_end = 1'b1;
        @(negedge clk);
        check("tick_move", sif.pos_x, 298);
        repeat (8) @(negedge clk);
        check("held_no_move", sif.pos_x, 298);
        sif.frame_end = 1'b0;
        repeat (2) @(negedge clk);
        check("after_drop", sif.pos_x, 298);

        // Walk left into the right player's goal.
        for (int i = 0; i < 9; i++) left(4'd15);
        check("walk_163", sif.pos_x, 163);
        check("no_goal_163", goalRCnt, 0);
        left(4'd6);
        check("walk_157", sif.pos_x, 157);
        check("goal_r_pulse", goalRCnt, 1);
        check("score_r_1", sif.score_r, 1);
        left(4'd7);
        for (int i = 0; i < 5; i++) left(4'd0);
        check("hold_150", sif.pos_x, 150);
        check("latched_score", sif.score_r, 1);
        check("latched_pulses", goalRCnt, 1);
        right(4'd10);
        left(4'd10);
        check("equal_no_rearm", sif.score_r, 1);
        right(4'd15);
        right(4'd15);
        right(4'd15);
        right(4'd5);
        check("back_200", sif.pos_x, 200);
        left(4'd15);
        left(4'd15);
        left(4'd10);
        check("equal_no_score", sif.score_r, 1);
        left(4'd5);
        check("rescore", sif.score_r, 2);
        check("rescore_pulses", goalRCnt, 2);

        // Clamp at the left edge; up beats down.
        for (int i = 0; i < 10; i++) left(4'd15);
        check("walk_5", sif.pos_x, 5);
        left(4'd15);
        check("clamp_x0", sif.pos_x, 0);
        doFrame(1'b0, 1'b0, 1'b1, 1'b1, 4'd15, 1'b0);
        check("up_over_down", sif.pos_y, 200);
        check("x_untouched", sif.pos_x, 0);

        // Run score_r to saturation.
        for (int i = 0; i < 11; i++) right(4'd15);
        for (int i = 0; i < 97; i++) begin
            left(4'd15);
            if (i == 7) check("score_ten", sif.score_r, TEN);
            right(4'd15);
        end
        check("score_full", sif.score_r, SAT);
        cntBefore = goalRCnt;
        left(4'd15);
        check("sat_pulse", goalRCnt - cntBefore, 1);
        check("sat_hold", sif.score_r, SAT);

        // Clear in the same cycle as a goal.
        right(4'd15);
        cntBefore = goalRCnt;
        doFrame(1'b1, 1'b0, 1'b0, 1'b0, 4'd15, 1'b1);
        check("clear_score", sif.score_r, 0);
        check("clear_no_pulse", goalRCnt - cntBefore, 0);
        check("clear_pos", sif.pos_x, 150);

        // Cross the right goal.
        for (int i = 0; i < 19; i++) right(4'd15);
        check("walk_435", sif.pos_x, 435);
        check("score_l_1", sif.score_l, 1);
        check("goal_l_pulse", goalLCnt, 1);

        // Hit test at (100,100).
        for (int i = 0; i < 22; i++) left(4'd15);
        left(4'd5);
        for (int i = 0; i < 6; i++) up(4'd15);
        up(4'd10);
        check("hit_pos_x", sif.pos_x, 100);
        check("hit_pos_y", sif.pos_y, 100);
        sif.pix_x = 10'd101;
        sif.pix_y = 9'd101;
        @(negedge clk);
        check("hit_inner", sif.hit, 1);
        check("rom_inner", sif.rom_addr, 37551);
        sif.pix_x = 10'd100;
        sif.pix_y = 9'd120;
        @(negedge clk);
        check("hit_left_edge", sif.hit, 0);
        sif.pix_x = 10'd149;
        sif.pix_y = 9'd149;
        @(negedge clk);
        check("hit_corner", sif.hit, 1);
        check("rom_corner", sif.rom_addr, 39999);
        sif.pix_x = 10'd150;
        sif.pix_y = 9'd130;
        @(negedge clk);
        check("hit_right_edge", sif.hit, 0);

        // Reset while frame_end is high.
        sif.mv_left = 1'b0;
        sif.mv_right = 1'b0;
        sif.mv_up = 1'b0;
        sif.mv_down = 1'b0;
        sif.frame_end = 1'b1;
        @(negedge clk);
        #2 reset = 1'b1;
        #1;
        check("midrst_pos_x", sif.pos_x, 295);
        check("midrst_pos_y", sif.pos_y, 215);
        check("midrst_score_l", sif.score_l, 0);
        @(negedge clk);
        reset = 1'b0;
        sif.mv_right = 1'b1;
        sif.step = 4'd3;
        repeat (3) @(negedge clk);
        check("no_tick_after_rst", sif.pos_x, 295);
        sif.frame_end = 1'b0;
        @(negedge clk);
        sif.frame_end = 1'b1;
        @(negedge clk);
        check("first_tick_after_rst", sif.pos_x, 298);
        sif.frame_end = 1'b0;
        @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
        $finish;
    end
endmodule
